// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encodings,
// flag-vector bit positions and the shifter mode type.
package alu_pkg;

  // Operation codes; 11..15 are unassigned and pass operand a through
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Bit positions inside the packed flag vector {C,Z,V,S}
  localparam int FLAG_S = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  // Shifter operating modes
  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_ROL = 2'd1,
    SH_SRL = 2'd2,
    SH_SRA = 2'd3
  } shift_mode_t;

  // Builds the flag vector in the shared {C,Z,V,S} order
  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic v, input logic s);
    return {c, z, v, s};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for the sequential ALU.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         S;
  logic         V;
  logic         Z;
  logic         C;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, S, V, Z, C
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, S, V, Z, C
  );
endinterface

// File: rtl/alu_shift.sv
// Combinational shifter/rotator. Each mode works on a double-width
// extension so the bit shifted out lands at a fixed position, which
// gives the carry without a variable bit select. Amount 0 yields carry 0.
module alu_shift
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]         value,
  input  logic [$clog2(W)-1:0] amount,
  input  shift_mode_t          mode,
  output logic [W-1:0]         shifted,
  output logic                 carry
);

  logic [2*W-1:0] ext;

  // Select the shift flavour and pick result/carry out of the extension
  always_comb begin
    ext     = '0;
    shifted = '0;
    carry   = 1'b0;
    case (mode)
      SH_SLL: begin
        ext     = {{W{1'b0}}, value} << amount;
        shifted = ext[W-1:0];
        carry   = ext[W];
      end
      SH_ROL: begin
        ext     = {value, value} << amount;
        shifted = ext[2*W-1:W];
      end
      SH_SRL: begin
        ext     = {value, {W{1'b0}}} >> amount;
        shifted = ext[2*W-1:W];
        carry   = ext[W-1];
      end
      SH_SRA: begin
        ext     = $signed({value, {W{1'b0}}}) >>> amount;
        shifted = ext[2*W-1:W];
        carry   = ext[W-1];
      end
      default: begin
        shifted = value;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accepting edge; MUL is a shift-add
// multiplier that consumes one bit of b per cycle and finishes W cycles
// after acceptance. Result and flags are registered and held until taken.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = 16,
  parameter int SH = $clog2(W)
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  logic [0:0]     state;
  logic           out_valid_q;
  logic [W-1:0]   result_q;
  logic [3:0]     flags_q;

  logic [SH-1:0]  mul_cnt;
  logic [2*W-1:0] mul_acc;
  logic [2*W-1:0] mul_mcand;
  logic [W-1:0]   mul_mplier;

  logic           in_ready;
  logic           accept;

  shift_mode_t    shift_mode;
  logic [W-1:0]   shift_res;
  logic           shift_c;

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;

  logic [2*W-1:0] mul_add;
  logic           mul_last;
  logic           mul_hi_nz;
  logic [W-1:0]   mul_lo;

  // A new op may enter only when idle and the output slot is free or draining
  assign in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready) && !rst;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.S         = flags_q[FLAG_S];
  assign bus.V         = flags_q[FLAG_V];
  assign bus.Z         = flags_q[FLAG_Z];
  assign bus.C         = flags_q[FLAG_C];

  // Map the shift opcodes onto shifter modes
  always_comb begin
    shift_mode = SH_SLL;
    case (bus.op)
      OP_SLL:  shift_mode = SH_SLL;
      OP_ROL:  shift_mode = SH_ROL;
      OP_SRL:  shift_mode = SH_SRL;
      OP_SRA:  shift_mode = SH_SRA;
      default: shift_mode = SH_SLL;
    endcase
  end

  alu_shift #(
    .W(W)
  ) u_shift (
    .value  (bus.a),
    .amount (bus.b[SH-1:0]),
    .mode   (shift_mode),
    .shifted(shift_res),
    .carry  (shift_c)
  );

  // Single-cycle datapath: result plus carry/overflow for each opcode
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res = bus.a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (bus.a[W-1] == bus.b[W-1]) && (alu_res[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
        alu_v   = (bus.a[W-1] != bus.b[W-1]) && (alu_res[W-1] != bus.a[W-1]);
      end
      OP_MOV: alu_res = bus.b;
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_res = shift_res;
        alu_c   = shift_c;
      end
      OP_ROL: alu_res = shift_res;
      default: alu_res = bus.a;
    endcase
  end

  // One shift-add step; the last step's sum is the full product
  assign mul_add   = mul_acc + (mul_mplier[0] ? mul_mcand : {(2*W){1'b0}});
  assign mul_last  = (mul_cnt == SH'(W - 1));
  assign mul_hi_nz = |mul_add[2*W-1:W];
  assign mul_lo    = mul_add[W-1:0];

  // Control FSM, output registers and multiplier state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      mul_cnt     <= '0;
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              state       <= ST_MUL;
              out_valid_q <= 1'b0;
              mul_cnt     <= '0;
              mul_acc     <= '0;
              mul_mcand   <= {{W{1'b0}}, bus.a};
              mul_mplier  <= bus.b;
            end else begin
              result_q    <= alu_res;
              flags_q     <= pack_flags(alu_c, alu_res == '0, alu_v, alu_res[W-1]);
              out_valid_q <= 1'b1;
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          mul_acc    <= mul_add;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + 1'b1;
          if (mul_last) begin
            state       <= ST_IDLE;
            mul_cnt     <= '0;
            result_q    <= mul_lo;
            flags_q     <= pack_flags(mul_hi_nz, mul_lo == '0, mul_hi_nz, mul_lo[W-1]);
            out_valid_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=16): directed operations push their
// hand-computed results into a queue, and a monitor pops and compares
// each result the DUT hands over. Timing, back-pressure and reset-abort
// behaviour are checked directly by the stimulus process.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_if #(.W(W)) bus();

  alu_seq #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Single comparison with failure report
  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one op, wait (bounded) for acceptance, record its expected output
  task automatic apply_stimulus(input string name, input logic [3:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic [3:0] flags);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back('{name, res, flags});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been consumed
  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare every transferred result against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL spurious_output: got result 0x%0h, expected no output", bus.result);
        end else begin
          e = sb.pop_front();
          check_output({e.name, "_result"}, 32'(bus.result), 32'(e.res));
          check_output({e.name, "_flags"}, 32'({bus.C, bus.Z, bus.V, bus.S}), 32'(e.flags));
        end
      end
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    int   bad;
    logic seen;

    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_result", 32'(bus.result), 32'd0);
    check_output("reset_flags", 32'({bus.C, bus.Z, bus.V, bus.S}), 32'd0);
    check_output("reset_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    //               name            op      a         b         result    {C,Z,V,S}
    apply_stimulus("add_ovf",       OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
    apply_stimulus("sub_borrow",    OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1001);
    apply_stimulus("add_carry",     OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
    apply_stimulus("sra_1",         OP_SRA, 16'h8001, 16'h0001, 16'hC000, 4'b1001);
    apply_stimulus("sll_0",         OP_SLL, 16'h8001, 16'h0000, 16'h8001, 4'b0001);
    apply_stimulus("mov",           OP_MOV, 16'hFFFF, 16'h1234, 16'h1234, 4'b0000);
    apply_stimulus("and",           OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
    apply_stimulus("or",            OP_OR,  16'h8000, 16'h0001, 16'h8001, 4'b0001);
    apply_stimulus("xor_zero",      OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100);
    apply_stimulus("sll_1",         OP_SLL, 16'h8001, 16'h0001, 16'h0002, 4'b1000);
    apply_stimulus("rol_4_masked",  OP_ROL, 16'h8001, 16'h00F4, 16'h0018, 4'b0000);
    apply_stimulus("srl_1",         OP_SRL, 16'h8001, 16'h0001, 16'h4000, 4'b1000);
    apply_stimulus("sra_15",        OP_SRA, 16'h4000, 16'h000F, 16'h0000, 4'b1100);
    apply_stimulus("sub_ovf",       OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010);
    apply_stimulus("pass_op12",     4'd12,  16'h8005, 16'h1234, 16'h8005, 4'b0001);
    apply_stimulus("srl_0",         OP_SRL, 16'h0003, 16'h0000, 16'h0003, 4'b0000);
    drain();

    // MUL latency: busy for exactly W cycles, valid after the W-th edge
    apply_stimulus("mul_0100x0100", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1110);
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.in_ready) bad++;
    end
    check_output("mul_busy_cycles_bad", 32'(bad), 32'd0);
    @(negedge clk);
    check_output("mul_valid_at_W", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    apply_stimulus("mul_3x5",       OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000);
    apply_stimulus("mul_ffffxffff", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1010);
    drain();

    // Back-pressure: result held, new requests ignored
    bus.out_ready = 1'b0;
    apply_stimulus("add_3_4", OP_ADD, 16'h0003, 16'h0004, 16'h0007, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = OP_ADD;
      bus.a        = 16'h0001;
      bus.b        = 16'h0001;
      @(negedge clk);
      check_output("hold_result", 32'(bus.result), 32'h0007);
      check_output("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_output("release_in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    // Reset in the middle of a MUL aborts it
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.a        = 16'h0100;
    bus.b        = 16'h0100;
    check_output("abort_mul_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("abort_result", 32'(bus.result), 32'd0);
    check_output("abort_flags", 32'({bus.C, bus.Z, bus.V, bus.S}), 32'd0);
    check_output("abort_in_ready_in_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check_output("abort_no_output", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Normal operation resumes after the abort
    apply_stimulus("post_abort_xor", OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand and result width (W >= 4, power of two).
REQ-002 The block SHALL have parameter SH, default $clog2(W), giving the shift-amount width.
REQ-003 Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: reset is synchronous and active-high.
REQ-005 Port in_valid, input, 1: op, a and b are presented.
REQ-006 Port in_ready, output, 1: the block accepts an operation this cycle.
REQ-007 Port op, input, 4: operation code.
REQ-008 Ports a and b, input, W each: operands.
REQ-009 Port out_valid, output, 1: result and flags are valid.
REQ-010 Port out_ready, input, 1: the consumer takes the result.
REQ-011 Port result, output, W: registered result.
REQ-012 Ports S, V, Z, C, output, 1 each: registered sign, overflow, zero and carry flags.

Function
REQ-013 An operation SHALL be accepted in any cycle where in_valid && in_ready.
REQ-014 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !rst.
REQ-015 The FSM SHALL have states IDLE and MUL; on reset it SHALL enter IDLE.
REQ-016 Single-cycle ops SHALL update result/flags and set out_valid on the edge that accepts them; state stays IDLE.
REQ-017 out_valid SHALL clear on an edge where out_valid && out_ready and no new result is loaded.
REQ-018 While out_valid && !out_ready, result and flags SHALL hold stable.
REQ-019 The opcodes SHALL be: 0 ADD a+b, 1 SUB a-b, 2 MOV b, 3 AND, 4 OR, 5 XOR, 6 SLL a<<b[SH-1:0] zero-fill, 7 ROL a left by b[SH-1:0], 8 SRL zero-fill, 9 SRA sign-fill, 10 MUL (low W bits of unsigned a*b).
REQ-020 Opcodes 11-15 SHALL pass a through, with C=V=0.
REQ-021 S SHALL be result[W-1] for every op.
REQ-022 Z SHALL be (result==0) over W bits only, for every op.
REQ-023 ADD SHALL set C to the carry out of bit W-1 and V to two's-complement overflow (operands of equal sign, result sign differs).
REQ-024 SUB SHALL set C to the borrow (a<b unsigned) and V to signed overflow.
REQ-025 SLL SHALL set C to the last bit shifted out of the MSB; SRL and SRA SHALL set C to the last bit shifted out of the LSB; in all three, shift amount 0 gives C=0, and V=0.
REQ-026 MOV, logic ops and ROL SHALL set C=V=0.
REQ-027 MUL SHALL be iterative shift-add, one b bit per cycle, entering state MUL on acceptance.
REQ-028 MUL's out_valid SHALL rise exactly W cycles after the accepting edge, with in_ready low throughout.
REQ-029 MUL SHALL set C=V=1 iff the high W bits of the full 2W-bit product are nonzero.
REQ-030 On the edge that sets MUL out_valid, the FSM SHALL return to IDLE.
REQ-031 in_valid while in_ready is low SHALL be ignored; the block SHALL not buffer it.

Reset
REQ-032 While rst is high, the block SHALL set out_valid=0, result=0, S=V=Z=C=0, state IDLE, and clear the MUL counter and accumulator.
REQ-033 rst asserted mid-MUL SHALL abort the operation with no result emitted; in_ready SHALL return to 1 in the first cycle after rst falls.

Structure
REQ-034 Opcode constants, state encodings and the flag-vector bit order {C,Z,V,S} SHALL live in shared package alu_pkg.
REQ-035 Shifting SHALL be a combinational sub-module alu_shift (parameter W; inputs value, amount and mode SLL/ROL/SRL/SRA; outputs shifted value and carry).

Verification (W=16)
REQ-036 ADD 0x7FFF+0x0001 -> next edge result 0x8000, S=1, V=1, Z=0, C=0.
REQ-037 SUB 0x0000-0x0001 -> result 0xFFFF, S=1, C=1, V=0; ADD 0xFFFF+0x0001 -> 0x0000, Z=1, C=1, V=0.
REQ-038 SRA 0x8001 by 1 -> 0xC000, C=1, S=1; SLL 0x8001 by 0 -> 0x8001, C=0.
REQ-039 MUL 0x0100*0x0100 -> result 0x0000, Z=1, C=1, V=1; out_valid exactly 16 cycles after accept; in_ready low meanwhile.
REQ-040 Hold out_ready=0 for 5 cycles after ADD 3+4 -> result 0x0007 stable, in_ready=0, in_valid ignored; out_ready=1 -> in_ready=1 in the same cycle.
REQ-041 Assert rst 5 cycles into a MUL -> out_valid never rises for it, all outputs 0, in_ready=1 the cycle after rst falls.
